spi_shift_engine: RTL and testbench
===================================

# spi_shift_engine

Serial shift stage of the SPI interface, sitting directly downstream of the control block: it consumes the sender load strobe and the TE/RE enables, and shifts one byte out on MOSI while shifting one byte in from MISO. It returns SENDER_EMPTY_STATE and RECEIVER_FULL_STATE to the control block. In master mode it generates SCLK and SS_N from CLK. In slave mode it follows an external SCLK and SS_N, which it synchronises into the CLK domain.

## Interface
- DATA_W, 8: frame width in bits.
- CLK_DIV, 4: master SCLK half-period in CLK cycles; must be ≥2.
- CLK  in  1  system clock; all state is on the rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- MS_MODE  in  1  1 = master, 0 = slave; sampled only in IDLE.
- TE  in  1  transmit enable.
- RE  in  1  receive enable.
- SENDER_WRITE  in  1  one-cycle strobe; loads TX_DATA.
- TX_DATA  in  DATA_W  byte to send.
- RECEIVER_READ  in  1  one-cycle strobe; the consumer has taken RX_DATA.
- SENDER_EMPTY_STATE  out  1  1 = tx holding register empty.
- RECEIVER_FULL_STATE  out  1  1 = RX_DATA holds an unread frame.
- RX_DATA  out  DATA_W  last received frame.
- OVERRUN  out  1  sticky; set when a frame completes while RECEIVER_FULL_STATE = 1.
- SCLK_OUT / SS_N_OUT  out  1  master clock and select; idle values 0 and 1.
- SCLK_IN / SS_N_IN  in  1  slave clock and select; asynchronous to CLK.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.

## Operation
- SPI mode 0: SCLK idles low. Data is sampled on the SCLK rising edge and changed on the falling edge. Bit order is MSB first unless SPI_LSB_FIRST_EN is defined.
- Holding register:
  - SENDER_WRITE with SENDER_EMPTY_STATE = 1: capture TX_DATA and clear empty.
  - SENDER_WRITE with SENDER_EMPTY_STATE = 0: ignored; data is not overwritten.
- FSM states and transitions:
  - IDLE → LOAD: when TE = 1 and holding register full (master), or SS_N_IN synchronised low (slave).
  - LOAD (1 cycle): copy holding register to shift register and set SENDER_EMPTY_STATE = 1.
    - Slave with holding register empty: shift register is loaded with all-zeros.
  - LOAD → SHIFT: bit counter = DATA_W.
  - SHIFT: each sample edge captures MISO; each shift edge advances MOSI. Counter decrements on the sample edge. Leave SHIFT after the sample edge that brings the counter to 0.
  - SHIFT → DONE (1 cycle):
    - If RE = 1: write the frame to RX_DATA and set RECEIVER_FULL_STATE.
    - If RECEIVER_FULL_STATE was already 1: set OVERRUN, and RX_DATA is still overwritten.
    - If RE = 0: the frame is discarded.
  - DONE → IDLE, or DONE → LOAD directly if master, TE = 1 and the holding register is full. SS_N_OUT stays low across back-to-back frames in that case.
- RECEIVER_READ clears RECEIVER_FULL_STATE. If RECEIVER_READ coincides with DONE writing a frame, full stays 1 and OVERRUN is not set.
- OVERRUN clears only on reset.
- TE dropped mid-frame: the current frame completes, and no new frame starts.
- Slave, SS_N_IN rising mid-frame: abort to IDLE. RX_DATA and the flags are not updated, and the partial frame is lost.
- Reset: FSM = IDLE, SENDER_EMPTY_STATE = 1, RECEIVER_FULL_STATE = 0, OVERRUN = 0, RX_DATA = 0, SCLK_OUT = 0, SS_N_OUT = 1, MOSI = 0.

## Timing
- Master:
  - SS_N_OUT falls in LOAD.
  - MOSI shows the first bit in the same cycle.
  - First SCLK_OUT rising edge comes CLK_DIV cycles after LOAD.
  - SCLK period = 2·CLK_DIV cycles.
  - Frame latency from LOAD to DONE = 2·CLK_DIV·DATA_W cycles.
  - SS_N_OUT rises in the cycle after DONE unless a back-to-back frame starts.
- Slave:
  - SCLK_IN and SS_N_IN pass through 2-flop synchronisers; edge detection adds 3 CLK cycles of latency.
  - Requires SCLK_IN half-period ≥4 CLK cycles.
  - MOSI updates 3 cycles after the falling SCLK_IN edge.
- RX_DATA and RECEIVER_FULL_STATE are valid the cycle after DONE.
- SENDER_EMPTY_STATE rises the cycle after LOAD.

## Configuration
- SPI_LSB_FIRST_EN defined: bit 0 goes out first on MOSI, and received bits fill from bit DATA_W-1 downward so RX_DATA is correctly ordered.
- Not defined: MSB first on both directions.

## Structure
- Package spi_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE);
  - default DATA_W;
  - default CLK_DIV.
- Sub-module spi_sclk_gen:
  - master divider producing SCLK_OUT plus one-cycle sample/shift edge pulses;
  - slave synchroniser and edge detector producing the same pulses;
  - selected by MS_MODE.

## Test plan
- Master, CLK_DIV = 4: write 0xA5 with TE = 1, RE = 1, MISO looped to MOSI.
  - MOSI bits 1,0,1,0,0,1,0,1.
  - RX_DATA = 0xA5 and RECEIVER_FULL_STATE = 1 at LOAD + 65 cycles.
- Back-to-back: write 0x3C, then write 0xC3 during SHIFT.
  - SS_N_OUT stays low for 16 SCLK pulses.
  - SENDER_EMPTY_STATE = 1 after the second LOAD.
- Overrun: receive two frames (0x11, 0x22) without RECEIVER_READ.
  - RX_DATA = 0x22 and OVERRUN = 1.
  - A third frame whose RECEIVER_READ coincides with DONE keeps RECEIVER_FULL_STATE = 1.
- Slave, SCLK_IN half-period 6 cycles, master sends 0x5A.
  - RX_DATA = 0x5A.
  - MOSI returns the preloaded 0x81.
  - SS_N_IN raised after 4 bits: FSM back to IDLE and RECEIVER_FULL_STATE stays 0.
- Assert CLR low mid-SHIFT.
  - All outputs return to their reset values asynchronously: SS_N_OUT = 1 and SENDER_EMPTY_STATE = 1.
- RE = 0 while a frame of 0xFF completes.
  - RX_DATA unchanged at 0x00 and RECEIVER_FULL_STATE = 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI shift engine.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_e;

    localparam int SPI_DATA_W  = 8;
    localparam int SPI_CLK_DIV = 4;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK source for the shift engine: master divider or slave synchroniser/edge detector,
// both producing one-cycle sample/shift pulses in the CLK domain.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ms_mode,
    input  logic run,
    input  logic sclk_in,
    input  logic ss_n_in,
    output logic sclk_out,
    output logic sample_pulse,
    output logic shift_pulse,
    output logic ss_n_sync
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic [2:0]       sclk_sync_q, sclk_sync_d;
    logic [1:0]       ss_sync_q, ss_sync_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             m_edge;

    always_comb begin
        div_d  = DIV_LAST;
        sclk_d = 1'b0;
        if (run) begin
            if (div_q == '0) begin
                div_d  = DIV_LAST;
                sclk_d = ~sclk_q;
            end else begin
                div_d  = div_q - 1'b1;
                sclk_d = sclk_q;
            end
        end
        sclk_sync_d = {sclk_sync_q[1:0], sclk_in};
        ss_sync_d   = {ss_sync_q[0], ss_n_in};
        // Registered edge pulses give a fixed 3-cycle latency from the pin.
        rise_d      = sclk_sync_q[1] & ~sclk_sync_q[2];
        fall_d      = ~sclk_sync_q[1] & sclk_sync_q[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= DIV_LAST;
            sclk_q      <= 1'b0;
            sclk_sync_q <= 3'b000;
            ss_sync_q   <= 2'b11;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            div_q       <= div_d;
            sclk_q      <= sclk_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    // Master samples and shifts together on the last CLK of the high phase,
    // i.e. at the clock edge where SCLK falls.
    assign m_edge       = run && (div_q == '0) && sclk_q;
    assign sclk_out     = sclk_q;
    assign sample_pulse = ms_mode ? m_edge : rise_q;
    assign shift_pulse  = ms_mode ? m_edge : fall_q;
    assign ss_n_sync    = ss_sync_q[1];

endmodule

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shift stage (master or slave) with tx holding register and rx flags.
// Define SPI_LSB_FIRST_EN for LSB-first framing; default is MSB first.
//   state  | meaning
//   IDLE   | waiting for TE + full holding reg (master) or SS low (slave)
//   LOAD   | holding reg -> shift reg, bit counter armed
//   SHIFT  | bits moving on sample/shift pulses
//   DONE   | frame handed to RX_DATA when RE
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              MS_MODE,
    input  logic              TE,
    input  logic              RE,
    input  logic              SENDER_WRITE,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              RECEIVER_READ,
    output logic              SENDER_EMPTY_STATE,
    output logic              RECEIVER_FULL_STATE,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              OVERRUN,
    output logic              SCLK_OUT,
    output logic              SS_N_OUT,
    input  logic              SCLK_IN,
    input  logic              SS_N_IN,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef SPI_LSB_FIRST_EN
    localparam int TX_BIT = 0;
`else
    localparam int TX_BIT = DATA_W - 1;
`endif

    spi_state_e        state_q, state_d;
    logic              ms_q, ms_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              empty_q, empty_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              full_q, full_d;
    logic              ovr_q, ovr_d;

    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] rx_next;
    logic              run;
    logic              sample_pulse;
    logic              shift_pulse;
    logic              ss_n_sync;
    logic              mosi_c;

    // A slave selected with nothing queued still has to clock out something.
    assign load_val = empty_q ? '0 : hold_q;

`ifdef SPI_LSB_FIRST_EN
    assign shift_next = {1'b0, shift_q[DATA_W-1:1]};
    assign rx_next    = {MISO, rx_q[DATA_W-1:1]};
`else
    assign shift_next = {shift_q[DATA_W-2:0], 1'b0};
    assign rx_next    = {rx_q[DATA_W-2:0], MISO};
`endif

    assign run = ms_q && ((state_q == ST_LOAD) || (state_q == ST_SHIFT));

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk         (CLK),
        .rst_n       (CLR),
        .ms_mode     (ms_q),
        .run         (run),
        .sclk_in     (SCLK_IN),
        .ss_n_in     (SS_N_IN),
        .sclk_out    (SCLK_OUT),
        .sample_pulse(sample_pulse),
        .shift_pulse (shift_pulse),
        .ss_n_sync   (ss_n_sync)
    );

    always_comb begin
        state_d   = state_q;
        ms_d      = ms_q;
        hold_d    = hold_q;
        empty_d   = empty_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        rx_data_d = rx_data_q;
        full_d    = full_q;
        ovr_d     = ovr_q;

        if (RECEIVER_READ) begin
            full_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                ms_d = MS_MODE;
                if (MS_MODE ? (TE && !empty_q) : !ss_n_sync) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d = load_val;
                empty_d = 1'b1;
                cnt_d   = CNT_W'(DATA_W);
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!ms_q && ss_n_sync) begin
                    state_d = ST_IDLE;
                end else begin
                    if (shift_pulse) begin
                        shift_d = shift_next;
                    end
                    if (sample_pulse) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (RE) begin
                    rx_data_d = rx_q;
                    full_d    = 1'b1;
                    if (full_q && !RECEIVER_READ) begin
                        ovr_d = 1'b1;
                    end
                end
                state_d = (ms_q && TE && !empty_q) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Placed after LOAD so a write landing on a slave's empty LOAD is kept.
        if (SENDER_WRITE && empty_q) begin
            hold_d  = TX_DATA;
            empty_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= ST_IDLE;
            ms_q      <= 1'b0;
            hold_q    <= '0;
            empty_q   <= 1'b1;
            shift_q   <= '0;
            rx_q      <= '0;
            cnt_q     <= '0;
            rx_data_q <= '0;
            full_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_q      <= ms_d;
            hold_q    <= hold_d;
            empty_q   <= empty_d;
            shift_q   <= shift_d;
            rx_q      <= rx_d;
            cnt_q     <= cnt_d;
            rx_data_q <= rx_data_d;
            full_q    <= full_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        mosi_c = 1'b0;
        case (state_q)
            ST_LOAD:           mosi_c = load_val[TX_BIT];
            ST_SHIFT, ST_DONE: mosi_c = shift_q[TX_BIT];
            default:           mosi_c = 1'b0;
        endcase
    end

    assign MOSI                = mosi_c;
    assign SS_N_OUT            = !(ms_q && (state_q != ST_IDLE));
    assign SENDER_EMPTY_STATE  = empty_q;
    assign RECEIVER_FULL_STATE = full_q;
    assign RX_DATA             = rx_data_q;
    assign OVERRUN             = ovr_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: directed cases plus randomized master frames.
module tb_spi_shift_engine;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       MS_MODE = 1'b0;
    logic       TE = 1'b0;
    logic       RE = 1'b0;
    logic       SENDER_WRITE = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       RECEIVER_READ = 1'b0;
    logic       SENDER_EMPTY_STATE;
    logic       RECEIVER_FULL_STATE;
    logic [7:0] RX_DATA;
    logic       OVERRUN;
    logic       SCLK_OUT;
    logic       SS_N_OUT;
    logic       SCLK_IN = 1'b0;
    logic       SS_N_IN = 1'b1;
    logic       MOSI;
    logic       MISO;
    logic       miso_drv = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    // monitor state for master frames, counted in CLK cycles from LOAD
    int          cyc, rises, first_rise, ss_high, wr_at, rd_at;
    logic [7:0]  wr_val;
    logic [15:0] wire_bits;
    logic        sclk_prev;

    // reference model of the receive side
    logic [7:0] exp_rx;
    logic       exp_full;
    logic       exp_ovr;

    always #5 CLK = ~CLK;

    // master frames loop MOSI back to MISO; slave frames take MISO from the bench
    assign MISO = MS_MODE ? MOSI : miso_drv;

    spi_shift_engine dut (
        .CLK                (CLK),
        .CLR                (CLR),
        .MS_MODE            (MS_MODE),
        .TE                 (TE),
        .RE                 (RE),
        .SENDER_WRITE       (SENDER_WRITE),
        .TX_DATA            (TX_DATA),
        .RECEIVER_READ      (RECEIVER_READ),
        .SENDER_EMPTY_STATE (SENDER_EMPTY_STATE),
        .RECEIVER_FULL_STATE(RECEIVER_FULL_STATE),
        .RX_DATA            (RX_DATA),
        .OVERRUN            (OVERRUN),
        .SCLK_OUT           (SCLK_OUT),
        .SS_N_OUT           (SS_N_OUT),
        .SCLK_IN            (SCLK_IN),
        .SS_N_IN            (SS_N_IN),
        .MOSI               (MOSI),
        .MISO               (MISO)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // order in which a byte's bits appear on the wire
    function automatic logic [7:0] wire_order(input logic [7:0] b);
        logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = b[i];
`else
        r = b;
`endif
        return r;
    endfunction

    task automatic do_reset();
        CLR = 1'b0; MS_MODE = 1'b0; TE = 1'b0; RE = 1'b0;
        SENDER_WRITE = 1'b0; RECEIVER_READ = 1'b0;
        SCLK_IN = 1'b0; SS_N_IN = 1'b1; miso_drv = 1'b0;
        repeat (2) @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        exp_rx = 8'h00; exp_full = 1'b0; exp_ovr = 1'b0;
    endtask

    task automatic write_tx(input logic [7:0] v);
        @(negedge CLK);
        TX_DATA = v; SENDER_WRITE = 1'b1;
        @(negedge CLK);
        SENDER_WRITE = 1'b0;
    endtask

    task automatic idle_read();
        @(negedge CLK);
        RECEIVER_READ = 1'b1;
        @(negedge CLK);
        RECEIVER_READ = 1'b0;
        exp_full = 1'b0;
    endtask

    task automatic wait_load();
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (SS_N_OUT && k < 40);
        check("load_seen", SS_N_OUT, 1'b0);
        cyc = 0; rises = 0; first_rise = -1; ss_high = 0;
        wire_bits = 16'h0; sclk_prev = SCLK_OUT; wr_at = -1; rd_at = -1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge CLK);
            cyc++;
            if (cyc == wr_at) begin
                SENDER_WRITE = 1'b1; TX_DATA = wr_val;
            end else begin
                SENDER_WRITE = 1'b0;
            end
            RECEIVER_READ = (cyc == rd_at);
            if (SCLK_OUT && !sclk_prev) begin
                rises++;
                if (first_rise < 0) first_rise = cyc;
                wire_bits = {wire_bits[14:0], MOSI};
            end
            sclk_prev = SCLK_OUT;
            if (SS_N_OUT) ss_high++;
        end
    endtask

    task automatic master_frame(input logic [7:0] tx, input logic re, input logic rd_done);
        MS_MODE = 1'b1; TE = 1'b1; RE = re;
        write_tx(tx);
        wait_load();
        check("m_empty_in_load", SENDER_EMPTY_STATE, 1'b0);
        rd_at = rd_done ? 64 : -1;
        run_cycles(1);
        check("m_empty_after_load", SENDER_EMPTY_STATE, 1'b1);
        run_cycles(63);
        check("m_full_at_done", RECEIVER_FULL_STATE, exp_full);
        run_cycles(1);
        if (re) begin
            if (exp_full && !rd_done) exp_ovr = 1'b1;
            exp_rx   = tx;
            exp_full = 1'b1;
        end else if (rd_done) begin
            exp_full = 1'b0;
        end
        check("m_first_rise", first_rise, 4);
        check("m_rises", rises, 8);
        check("m_mosi_bits", wire_bits[7:0], wire_order(tx));
        check("m_ss_high_after", ss_high, 1);
        check("m_rx_data", RX_DATA, exp_rx);
        check("m_full", RECEIVER_FULL_STATE, exp_full);
        check("m_overrun", OVERRUN, exp_ovr);
        @(negedge CLK);
    endtask

    // bench acts as an SPI master on SCLK_IN/SS_N_IN, half-period 6 CLK cycles
    task automatic slave_xfer(input logic [7:0] m_byte, input int nbits, output logic [7:0] got);
        logic [7:0] w;
        w = wire_order(m_byte);
        got = 8'h00;
        SS_N_IN = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            miso_drv = w[7-i];
            repeat (6) @(negedge CLK);
            SCLK_IN = 1'b1;
            got = {got[6:0], MOSI};
            repeat (6) @(negedge CLK);
            SCLK_IN = 1'b0;
        end
        repeat (6) @(negedge CLK);
        SS_N_IN = 1'b1;
        repeat (12) @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] got;
        do_reset();
        check("rst_ss_n", SS_N_OUT, 1'b1);
        check("rst_sclk", SCLK_OUT, 1'b0);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_empty", SENDER_EMPTY_STATE, 1'b1);
        check("rst_full", RECEIVER_FULL_STATE, 1'b0);
        check("rst_ovr", OVERRUN, 1'b0);
        check("rst_rx", RX_DATA, 8'h00);

        // basic master loopback
        master_frame(8'hA5, 1'b1, 1'b0);

        // back-to-back frames with SS held low
        do_reset();
        MS_MODE = 1'b1; TE = 1'b1; RE = 1'b1;
        write_tx(8'h3C);
        wait_load();
        wr_at = 10; wr_val = 8'hC3;
        run_cycles(1);
        check("b2b_empty_1", SENDER_EMPTY_STATE, 1'b1);
        run_cycles(11);
        check("b2b_held", SENDER_EMPTY_STATE, 1'b0);
        run_cycles(54);
        check("b2b_empty_2", SENDER_EMPTY_STATE, 1'b1);
        run_cycles(63);
        check("b2b_ss_low", ss_high, 0);
        check("b2b_rises", rises, 16);
        check("b2b_bits", wire_bits, {wire_order(8'h3C), wire_order(8'hC3)});
        run_cycles(1);
        check("b2b_ss_rise", SS_N_OUT, 1'b1);
        check("b2b_rx", RX_DATA, 8'hC3);
        check("b2b_ovr", OVERRUN, 1'b1);

        // overrun, and read coinciding with DONE
        do_reset();
        master_frame(8'h11, 1'b1, 1'b0);
        master_frame(8'h22, 1'b1, 1'b0);
        master_frame(8'h33, 1'b1, 1'b1);
        do_reset();
        master_frame(8'h44, 1'b1, 1'b0);
        master_frame(8'h55, 1'b1, 1'b1);

        // discarded frame
        do_reset();
        master_frame(8'hFF, 1'b0, 1'b0);

        // async reset mid-SHIFT
        do_reset();
        MS_MODE = 1'b1; TE = 1'b1; RE = 1'b1;
        write_tx(8'h96);
        wait_load();
        run_cycles(20);
        check("clr_pre_sclk", SCLK_OUT, 1'b1);
        check("clr_pre_ss", SS_N_OUT, 1'b0);
        #2 CLR = 1'b0;
        #1;
        check("clr_ss_n", SS_N_OUT, 1'b1);
        check("clr_empty", SENDER_EMPTY_STATE, 1'b1);
        check("clr_sclk", SCLK_OUT, 1'b0);
        check("clr_mosi", MOSI, 1'b0);

        // slave: aborted frame then a full frame
        do_reset();
        TE = 1'b1; RE = 1'b1;
        slave_xfer(8'hF0, 4, got);
        check("abort_full", RECEIVER_FULL_STATE, 1'b0);
        check("abort_rx", RX_DATA, 8'h00);
        write_tx(8'h81);
        check("sl_preload", SENDER_EMPTY_STATE, 1'b0);
        slave_xfer(8'h5A, 8, got);
        check("sl_mosi", got, wire_order(8'h81));
        check("sl_rx", RX_DATA, 8'h5A);
        check("sl_full", RECEIVER_FULL_STATE, 1'b1);
        check("sl_empty", SENDER_EMPTY_STATE, 1'b1);
        check("sl_ovr", OVERRUN, 1'b0);

        // randomized master frames against the model
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) idle_read();
            master_frame(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
